hv_similarity_accum: RTL
========================

# hv_similarity_accum

- Streaming similarity kernel, parametrised successor of the single-channel cosine kernel.
- Takes one query hypervector chunk `a_in` and `NUM_CHANNELS` candidate chunks `b_in` per beat. Accumulates, per channel, the terms needed for cosine similarity (AA, BB[c], AB[c]) or, in Hamming mode, the bit-distance AB[c].
- Sits between the HV memory readers and the classifier argmax stage. The 3-stage pipeline accepts one beat per clock.

## Interface
- `HV_DATA_WIDTH`, 32: bits per chunk per vector.
- `ELEM_WIDTH`, 8: signed element width; must divide `HV_DATA_WIDTH`. `LANES = HV_DATA_WIDTH/ELEM_WIDTH`.
- `NUM_CHANNELS`, 2: number of candidate vectors compared in parallel.
- `ACC_WIDTH`, 32: accumulator and output width, signed.
- `clk` in 1: the block's single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid` in 1: beat present.
- `first` in 1: beat is the first of a frame.
- `last` in 1: beat is the last of a frame.
- `mode` in 1: 0 = dot-product (cosine terms), 1 = Hamming. Sampled on the `first` beat.
- `a_in` in `HV_DATA_WIDTH`: query chunk.
- `b_in` in `NUM_CHANNELS*HV_DATA_WIDTH`: candidate chunks; channel c occupies bits [c*HV_DATA_WIDTH +: HV_DATA_WIDTH].
- `ready` out 1: a beat is accepted when `valid && ready`.
- `done` out 1: one-cycle pulse; results are valid.
- `AA_out` out `ACC_WIDTH`: sum of a·a.
- `BB_out` out `NUM_CHANNELS*ACC_WIDTH`: sum of b[c]·b[c] per channel.
- `AB_out` out `NUM_CHANNELS*ACC_WIDTH`: sum of a·b[c] per channel, or the Hamming distance.
- `overflow` out 1: sticky per frame; any accumulator saturated.

## Operation
- **States:** IDLE, ACCUM, DRAIN.
  - `ready`=1 in IDLE and ACCUM; `ready`=0 in DRAIN.
- **IDLE:**
  - An accepted beat with `first` enters ACCUM.
  - An accepted beat with `first && last` enters DRAIN.
  - A beat without `first` is ignored and dropped.
- **ACCUM:**
  - Every accepted beat is pushed into the pipeline.
  - An accepted `last` beat moves the FSM to DRAIN.
  - An accepted `first` beat restarts the frame: the new mode is latched and the old frame never raises `done`.
- **DRAIN:** after the last beat exits stage 3, the FSM returns to IDLE and pulses `done`.
- **Beat tags:** each beat carries `first`/`last`/mode tags down the pipeline. At stage 3 a `first`-tagged beat loads the accumulators (rather than adding) and clears `overflow`.
- **Dot mode arithmetic:**
  - Per lane, signed `ELEM_WIDTH`×`ELEM_WIDTH` products (2*ELEM_WIDTH bits).
  - Adder tree over lanes: 2*ELEM_WIDTH+clog2(LANES) bits.
  - Sign-extended to `ACC_WIDTH` and added to the accumulator.
- **Hamming mode:**
  - `AB[c]` += popcount(a ^ b[c]), zero-extended.
  - `AA` and `BB` are held at 0.
- **Outputs:** `AA_out`/`BB_out`/`AB_out` are registered copies, updated only on the `done` cycle. They hold their values until the next `done` or reset.

## Timing
- **Reset values:** all outputs 0, except `ready` = 1 (IDLE). The pipeline valid bits clear.
- **Pipeline:**
  - Stage 1 registers the lane products.
  - Stage 2 registers the lane-sum per channel.
  - Stage 3 is the accumulator.
- **Latency:** with `last` accepted at edge N, the result registers update and `done`=1 from edge N+3 for exactly one cycle.
- **`ready` after `last`:** low from edge N to edge N+3. It is high in the `done` cycle, so a new `first` beat may be accepted in that cycle.
- **Throughput:** one beat per clock. `valid` gaps within a frame are allowed.
- **Reset mid-frame:** the frame is discarded and the block is in IDLE after release.

## Configuration
- **`SIM_SATURATE_EN` defined:** each accumulator clamps to the signed ACC_WIDTH maximum/minimum on overflow and sets `overflow`.
- **`SIM_SATURATE_EN` undefined:** accumulators wrap modulo 2^ACC_WIDTH and `overflow` is tied to 0.

## Structure
- **Package `hv_sim_pkg`:** FSM state enum, `sim_mode_e` (SIM_DOT, SIM_HAMMING), and lane-count/sum-width helper functions.
- **Sub-module `hv_sim_lane_reduce`:** one instance per (a, b) pair, plus one for (a, a). Contains the stage-1 products and the stage-2 adder tree or popcount.

## Test plan
All scenarios use defaults (32/8/2/32) unless noted. Lanes are listed MSB→LSB.
1. **Single-beat dot frame.** `first && last`, a=0x01020304, b0=0x01020304, b1=0xFFFFFFFF. Expect AA=30, BB0=30, BB1=4, AB0=30, AB1=0xFFFFFFF6 (−10). `done` at edge N+3.
2. **Three-beat frame with one idle gap.** a=0x01010101 and b0=0x02020202 every beat. Expect AA=12, BB0=48, AB0=24; `ready` low for exactly 3 cycles after `last`.
3. **Hamming frame.** a=0xFFFF0000, b0=0x0000FFFF, b1=0xFFFF0000, single beat, mode=1. Expect AB0=32, AB1=0, AA=BB=0.
4. **Overflow, ACC_WIDTH=16.** a=b=0x7F7F7F7F, single beat. Expect AA=0x7FFF with `overflow`=1 when the macro is defined; AA=0xFC04 with `overflow`=0 when undefined.
5. **Restart.** Two beats of a=0x05050505, then a `first && last` beat with a=0x01010101. Expect exactly one `done`, with AA=4.
6. **Reset mid-frame.** Assert `reset_n`=0 after two beats. Expect all outputs 0 and `ready`=1. A subsequent frame (scenario 1 stimulus) yields scenario 1's results.

Source files
------------

// File: rtl/hv_sim_pkg.sv
// hv_sim_pkg: shared FSM/mode types and width helpers for hv_similarity_accum
// and its lane-reduction sub-module.
package hv_sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } hv_sim_state_e;

    typedef enum logic {
        SIM_DOT     = 1'b0,
        SIM_HAMMING = 1'b1
    } sim_mode_e;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int lane_count(input int hv_w, input int elem_w);
        return hv_w / elem_w;
    endfunction

    // Full-precision product width plus the growth of the adder tree.
    function automatic int sum_width(input int hv_w, input int elem_w);
        return 2 * elem_w + $clog2(lane_count(hv_w, elem_w));
    endfunction

    // Stage-2 result width: must hold either a signed lane sum or an
    // unsigned popcount of a whole chunk (with a spare sign bit).
    function automatic int res_width(input int hv_w, input int elem_w);
        return max2(sum_width(hv_w, elem_w), $clog2(hv_w + 1) + 1);
    endfunction

endpackage

// File: rtl/hv_sim_lane_reduce.sv
// hv_sim_lane_reduce: stage 1 (per-lane signed products and XOR of the two
// chunks) and stage 2 (lane adder tree or popcount) for one vector pair.
module hv_sim_lane_reduce
    import hv_sim_pkg::*;
#(
    parameter int HV_DATA_WIDTH = 32,
    parameter int ELEM_WIDTH    = 8,
    parameter int RES_W         = res_width(HV_DATA_WIDTH, ELEM_WIDTH)
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [HV_DATA_WIDTH-1:0] x_in,
    input  logic [HV_DATA_WIDTH-1:0] y_in,
    input  logic                     mode_s1,   // mode tag of the beat now in stage 1
    output logic signed [RES_W-1:0]  res_q
);
    localparam int LANES  = lane_count(HV_DATA_WIDTH, ELEM_WIDTH);
    localparam int PROD_W = 2 * ELEM_WIDTH;

    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic [HV_DATA_WIDTH-1:0]  diff_d;
    logic [HV_DATA_WIDTH-1:0]  diff_q;
    logic signed [RES_W-1:0]   sum_c;
    logic [RES_W-1:0]          pop_c;
    logic signed [RES_W-1:0]   res_d;

    // Operands are sign-extended before multiplying so the product keeps full precision.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [PROD_W-1:0] x_ext;
        logic signed [PROD_W-1:0] y_ext;
        assign x_ext      = PROD_W'($signed(x_in[gi*ELEM_WIDTH +: ELEM_WIDTH]));
        assign y_ext      = PROD_W'($signed(y_in[gi*ELEM_WIDTH +: ELEM_WIDTH]));
        assign prod_d[gi] = x_ext * y_ext;
    end

    assign diff_d = x_in ^ y_in;

    // Stage 1 register: products and bit difference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
            diff_q <= '0;
        end else begin
            prod_q <= prod_d;
            diff_q <= diff_d;
        end
    end

    // Stage 2 combinational: lane-sum in dot mode, popcount in Hamming mode.
    always_comb begin
        sum_c = '0;
        for (int l = 0; l < LANES; l++) sum_c = sum_c + RES_W'(prod_q[l]);
        pop_c = '0;
        for (int i = 0; i < HV_DATA_WIDTH; i++) pop_c = pop_c + RES_W'(diff_q[i]);
        if (mode_s1 == SIM_HAMMING) res_d = $signed(pop_c);
        else                        res_d = sum_c;
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) res_q <= '0;
        else          res_q <= res_d;
    end

endmodule

// File: rtl/hv_similarity_accum.sv
// hv_similarity_accum: streaming cosine/Hamming similarity accumulator.
// 3-stage pipeline (products, lane sums, accumulators) plus result registers
// updated on the done pulse. Define SIM_SATURATE_EN for saturating
// accumulators with a sticky overflow flag; otherwise accumulators wrap.
module hv_similarity_accum
    import hv_sim_pkg::*;
#(
    parameter int HV_DATA_WIDTH = 32,
    parameter int ELEM_WIDTH    = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int ACC_WIDTH     = 32
)(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 valid,
    input  logic                                 first,
    input  logic                                 last,
    input  logic                                 mode,
    input  logic [HV_DATA_WIDTH-1:0]             a_in,
    input  logic [NUM_CHANNELS*HV_DATA_WIDTH-1:0] b_in,
    output logic                                 ready,
    output logic                                 done,
    output logic [ACC_WIDTH-1:0]                 AA_out,
    output logic [NUM_CHANNELS*ACC_WIDTH-1:0]    BB_out,
    output logic [NUM_CHANNELS*ACC_WIDTH-1:0]    AB_out,
    output logic                                 overflow
);
    localparam int RES_W  = res_width(HV_DATA_WIDTH, ELEM_WIDTH);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ACCUM = ST_ACCUM;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
`ifdef SIM_SATURATE_EN
    localparam int WIDE_W = max2(ACC_WIDTH, RES_W) + 1;
    localparam logic signed [WIDE_W-1:0] SAT_MAX =
        {{(WIDE_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN =
        {{(WIDE_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`endif

    // Returns {saturated, next accumulator}; a load replaces rather than adds.
    function automatic logic [ACC_WIDTH:0] acc_step(input logic signed [ACC_WIDTH-1:0] acc,
                                                    input logic signed [RES_W-1:0] term,
                                                    input logic load);
`ifdef SIM_SATURATE_EN
        logic signed [WIDE_W-1:0] base;
        logic signed [WIDE_W-1:0] wide;
        if (load) base = '0;
        else      base = WIDE_W'(acc);
        wide = base + WIDE_W'(term);
        if (wide > SAT_MAX) return {1'b1, SAT_MAX[ACC_WIDTH-1:0]};
        if (wide < SAT_MIN) return {1'b1, SAT_MIN[ACC_WIDTH-1:0]};
        return {1'b0, wide[ACC_WIDTH-1:0]};
`else
        logic [ACC_WIDTH-1:0] base;
        if (load) base = '0;
        else      base = acc;
        return {1'b0, base + ACC_WIDTH'(term)};
`endif
    endfunction

    logic [1:0] state_q, state_d;
    logic       mode_q, mode_d;
    logic       s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
    logic       s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
    logic       s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic       s3_last_q, s3_last_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d, ovf_out_q, ovf_out_d;
    logic       push, sat, sat_any;
    logic signed [ACC_WIDTH-1:0] acc_aa_q, acc_aa_d;
    logic signed [ACC_WIDTH-1:0] acc_bb_q [NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc_bb_d [NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc_ab_q [NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc_ab_d [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]              aa_out_q, aa_out_d;
    logic [NUM_CHANNELS*ACC_WIDTH-1:0] bb_out_q, bb_out_d, ab_out_q, ab_out_d;
    logic signed [RES_W-1:0] res_aa;
    logic signed [RES_W-1:0] res_bb [NUM_CHANNELS];
    logic signed [RES_W-1:0] res_ab [NUM_CHANNELS];

    // In Hamming mode a^a and b^b are zero, so AA/BB naturally stay at 0.
    hv_sim_lane_reduce #(.HV_DATA_WIDTH(HV_DATA_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .RES_W(RES_W)) u_aa (
        .clk(clk), .reset_n(reset_n), .x_in(a_in), .y_in(a_in), .mode_s1(s1_mode_q), .res_q(res_aa)
    );

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        hv_sim_lane_reduce #(.HV_DATA_WIDTH(HV_DATA_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .RES_W(RES_W)) u_bb (
            .clk(clk), .reset_n(reset_n),
            .x_in(b_in[gi*HV_DATA_WIDTH +: HV_DATA_WIDTH]),
            .y_in(b_in[gi*HV_DATA_WIDTH +: HV_DATA_WIDTH]),
            .mode_s1(s1_mode_q), .res_q(res_bb[gi])
        );
        hv_sim_lane_reduce #(.HV_DATA_WIDTH(HV_DATA_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .RES_W(RES_W)) u_ab (
            .clk(clk), .reset_n(reset_n),
            .x_in(a_in),
            .y_in(b_in[gi*HV_DATA_WIDTH +: HV_DATA_WIDTH]),
            .mode_s1(s1_mode_q), .res_q(res_ab[gi])
        );
    end

    assign ready = (state_q != S_DRAIN);

    // Frame FSM, beat acceptance and pipeline tag propagation.
    always_comb begin
        push       = valid && ready && (first || state_q == S_ACCUM);
        mode_d     = (push && first) ? mode : mode_q;
        s1_valid_d = push;
        s1_first_d = first;
        s1_last_d  = last;
        s1_mode_d  = first ? mode : mode_q;
        s2_valid_d = s1_valid_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s3_last_d  = s2_valid_q && s2_last_q;
        state_d    = state_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (push && last)       state_d = S_DRAIN;
                else if (push && first) state_d = S_ACCUM;
            end
            S_DRAIN: begin
                if (s3_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 3 accumulators; a first-tagged beat loads and clears overflow.
    always_comb begin
        acc_aa_d = acc_aa_q;
        acc_bb_d = acc_bb_q;
        acc_ab_d = acc_ab_q;
        ovf_d    = ovf_q;
        sat      = 1'b0;
        sat_any  = 1'b0;
        if (s2_valid_q) begin
            {sat, acc_aa_d} = acc_step(acc_aa_q, res_aa, s2_first_q);
            sat_any = sat;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                {sat, acc_bb_d[c]} = acc_step(acc_bb_q[c], res_bb[c], s2_first_q);
                sat_any = sat_any | sat;
                {sat, acc_ab_d[c]} = acc_step(acc_ab_q[c], res_ab[c], s2_first_q);
                sat_any = sat_any | sat;
            end
            ovf_d = (s2_first_q ? 1'b0 : ovf_q) | sat_any;
        end
    end

    // Result registers capture the accumulators only on the done cycle.
    always_comb begin
        aa_out_d  = aa_out_q;
        bb_out_d  = bb_out_q;
        ab_out_d  = ab_out_q;
        ovf_out_d = ovf_out_q;
        if (done_d) begin
            aa_out_d  = acc_aa_q;
            ovf_out_d = ovf_q;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                bb_out_d[c*ACC_WIDTH +: ACC_WIDTH] = acc_bb_q[c];
                ab_out_d[c*ACC_WIDTH +: ACC_WIDTH] = acc_ab_q[c];
            end
        end
    end

    // All control, accumulator and output state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_out_q  <= 1'b0;
            acc_aa_q   <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_bb_q[c] <= '0;
                acc_ab_q[c] <= '0;
            end
            aa_out_q   <= '0;
            bb_out_q   <= '0;
            ab_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_first_q <= s2_first_d;
            s2_last_q  <= s2_last_d;
            s3_last_q  <= s3_last_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ovf_out_q  <= ovf_out_d;
            acc_aa_q   <= acc_aa_d;
            acc_bb_q   <= acc_bb_d;
            acc_ab_q   <= acc_ab_d;
            aa_out_q   <= aa_out_d;
            bb_out_q   <= bb_out_d;
            ab_out_q   <= ab_out_d;
        end
    end

    assign done     = done_q;
    assign AA_out   = aa_out_q;
    assign BB_out   = bb_out_q;
    assign AB_out   = ab_out_q;
    assign overflow = ovf_out_q;

endmodule
